instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL provide parameter RESET_PC, default 32'h0000_0000, as the first fetch address after reset.
REQ-002 The module SHALL provide ports:
- i_instr_fetch_clk  in  1  sole clock; all state updates on its rising edge.
- i_instr_fetch_rst  in  1  reset; synchronous, active-high.
- o_instr_fetch_imemReq  out  1  instruction-memory request valid.
- o_instr_fetch_imemAddr  out  32  request word address.
- i_instr_fetch_imemGnt  in  1  memory accepts the request this cycle.
- i_instr_fetch_imemRvalid  in  1  read data valid.
- i_instr_fetch_imemRdata  in  32  read data.
- o_instr_fetch_valid  out  1  decoded-instruction fields are valid.
- i_instr_fetch_ready  in  1  control unit/datapath consumes the instruction.
- o_instr_fetch_instr  out  32  instruction register.
- o_instr_fetch_opcode  out  6  instr[31:26], feeds the control-unit opcode input.
- o_instr_fetch_funct  out  6  instr[5:0], feeds the control-unit funct input.
- o_instr_fetch_pc  out  32  address of the held instruction.
- i_instr_fetch_redirect  in  1  branch/jump taken.
- i_instr_fetch_target  in  32  redirect address.

Function
REQ-003 The module SHALL implement states REQ, WAIT, HOLD and DRAIN.
REQ-004 In REQ: imemReq=1 and imemAddr=PC; on imemGnt, go to WAIT; otherwise stay.
REQ-005 In WAIT: on imemRvalid, load IR with imemRdata, load the held-PC register with PC, and go to HOLD.
REQ-006 In HOLD: valid=1 and IR is stable.
- On ready without redirect: PC <= PC+4 and go to REQ.
- Without ready: stay, with IR and all outputs unchanged.
REQ-007 opcode and funct SHALL be combinational slices of IR; both are zero out of reset.
REQ-008 Redirect, where newPC = {target[31:2], 2'b00}:
- In REQ without gnt: PC <= newPC; stay in REQ; next request uses newPC.
- In REQ with gnt in the same cycle: PC <= newPC; go to DRAIN.
- In WAIT: PC <= newPC; go to DRAIN, or to REQ if imemRvalid is high that cycle, in which case the data is discarded and IR is not loaded.
- In HOLD, with or without ready: PC <= newPC; valid drops next cycle; go to REQ. The instruction counts as consumed only if ready was high.
- In DRAIN: PC <= newPC; the latest target wins.
REQ-009 DRAIN SHALL wait for imemRvalid, discard that data, and go to REQ; imemReq=0 and valid=0 throughout.
REQ-010 At most one memory request SHALL be outstanding; imemReq SHALL be 0 in WAIT, HOLD and DRAIN.
REQ-011 valid SHALL be 1 only in HOLD; IR SHALL never change while valid=1.
REQ-012 PC+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-013 Latency from a REQ cycle with gnt and a one-cycle memory response (rvalid the cycle after gnt) to valid=1 SHALL be 2 cycles.
REQ-014 Back-to-back throughput with an always-ready consumer and immediate gnt SHALL be one instruction per 3 cycles.

Reset
REQ-015 While rst=1, the module SHALL hold: state=REQ, PC=RESET_PC, IR=0, held-PC=0, imemReq=0, valid=0.
REQ-016 rst SHALL override all inputs, including redirect, in the same cycle.
REQ-017 A response returning after reset SHALL be ignored unless it belongs to a request issued after reset. Because the memory is reset by the same signal, rvalid is not expected in REQ.
REQ-018 In the first cycle after rst deasserts, imemReq=1 and imemAddr=RESET_PC.

Verification
REQ-019 Reset with RESET_PC=0x3000, gnt and rvalid immediate, rdata=0x012A4020, ready=1. Required:
- imemAddr=0x3000.
- valid=1 two cycles after gnt.
- opcode=0x00, funct=0x20, pc=0x3000.
- next imemAddr=0x3004.
REQ-020 Backpressure: ready=0 for 5 cycles in HOLD. Required: valid held, IR and pc unchanged, imemReq=0; after ready=1, the next request is to pc+4.
REQ-021 Redirect in WAIT with target=0x4002 and rvalid arriving 3 cycles later. Required: the data is discarded and valid stays 0; the next request is to 0x4000.
REQ-022 Redirect and ready both high in HOLD. Required: the next imemAddr is the target, not pc+4.
REQ-023 Wrap: PC=0xFFFFFFFC consumed. Required: the next imemAddr is 0x00000000.
REQ-024 rst pulsed while in HOLD with valid=1. Required: valid=0 and IR=0 the next cycle; the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word request at a time, holds the returned
// instruction for the control unit and follows branch/jump redirects.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_instr_fetch_clk,
  input  logic        i_instr_fetch_rst,
  output logic        o_instr_fetch_imemReq,
  output logic [31:0] o_instr_fetch_imemAddr,
  input  logic        i_instr_fetch_imemGnt,
  input  logic        i_instr_fetch_imemRvalid,
  input  logic [31:0] i_instr_fetch_imemRdata,
  output logic        o_instr_fetch_valid,
  input  logic        i_instr_fetch_ready,
  output logic [31:0] o_instr_fetch_instr,
  output logic [5:0]  o_instr_fetch_opcode,
  output logic [5:0]  o_instr_fetch_funct,
  output logic [31:0] o_instr_fetch_pc,
  input  logic        i_instr_fetch_redirect,
  input  logic [31:0] i_instr_fetch_target
);

  // Handshakes: a memory request is accepted on a cycle with imemReq && imemGnt;
  // the one outstanding response arrives later on imemRvalid. An instruction is
  // consumed on a cycle with valid && ready.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetchState_e;

  fetchState_e state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] heldPc;
  logic [31:0] newPc;
  logic        unusedTargetLsbs;

  assign newPc            = {i_instr_fetch_target[31:2], 2'b00};
  assign unusedTargetLsbs = ^i_instr_fetch_target[1:0];

  always_ff @(posedge i_instr_fetch_clk) begin
    if (i_instr_fetch_rst) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      ir     <= '0;
      heldPc <= '0;
    end else begin
      case (state)
        S_REQ: begin
          // A response seen here can only belong to a pre-reset request.
          if (i_instr_fetch_redirect) begin
            pc <= newPc;
            if (i_instr_fetch_imemGnt) state <= S_DRAIN;
          end else if (i_instr_fetch_imemGnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_instr_fetch_redirect) begin
            pc    <= newPc;
            state <= i_instr_fetch_imemRvalid ? S_REQ : S_DRAIN;
          end else if (i_instr_fetch_imemRvalid) begin
            ir     <= i_instr_fetch_imemRdata;
            heldPc <= pc;
            state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_instr_fetch_redirect) begin
            pc    <= newPc;
            state <= S_REQ;
          end else if (i_instr_fetch_ready) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (i_instr_fetch_redirect) pc <= newPc;
          if (i_instr_fetch_imemRvalid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // Reset gates the strobes in the same cycle it is asserted.
  assign o_instr_fetch_imemReq  = (state == S_REQ) && !i_instr_fetch_rst;
  assign o_instr_fetch_valid    = (state == S_HOLD) && !i_instr_fetch_rst;
  assign o_instr_fetch_imemAddr = pc;
  assign o_instr_fetch_instr    = ir;
  assign o_instr_fetch_opcode   = ir[31:26];
  assign o_instr_fetch_funct    = ir[5:0];
  assign o_instr_fetch_pc       = heldPc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// randomized traffic against a flag-based transaction model checked every cycle.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pcOut;
  logic        redirect;
  logic [31:0] target;

  int cmpCount = 0;
  int errCount = 0;
  int hsCount  = 0;
  bit randomPhase = 1'b0;

  instr_fetch #(.RESET_PC(RPC)) dut (
    .i_instr_fetch_clk       (clk),
    .i_instr_fetch_rst       (rst),
    .o_instr_fetch_imemReq   (imemReq),
    .o_instr_fetch_imemAddr  (imemAddr),
    .i_instr_fetch_imemGnt   (gnt),
    .i_instr_fetch_imemRvalid(rvalid),
    .i_instr_fetch_imemRdata (rdata),
    .o_instr_fetch_valid     (valid),
    .i_instr_fetch_ready     (ready),
    .o_instr_fetch_instr     (instr),
    .o_instr_fetch_opcode    (opcode),
    .o_instr_fetch_funct     (funct),
    .o_instr_fetch_pc        (pcOut),
    .i_instr_fetch_redirect  (redirect),
    .i_instr_fetch_target    (target)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: a fetch is either idle (requesting), outstanding (maybe
  // doomed by a redirect), or holding an instruction for the consumer.
  bit          mStarted = 1'b0;
  bit          mHolding, mOutstanding, mDiscard;
  logic [31:0] mPc, mIr, mHeld;

  always @(posedge clk) begin : model
    bit          h, o, d;
    logic [31:0] p, r, hp, np;
    h = mHolding; o = mOutstanding; d = mDiscard;
    p = mPc; r = mIr; hp = mHeld;
    np = target & 32'hFFFF_FFFC;
    if (rst) begin
      h = 1'b0; o = 1'b0; d = 1'b0; p = RPC; r = '0; hp = '0;
    end else if (h) begin
      if (redirect) begin p = np; h = 1'b0; end
      else if (ready) begin p = p + 32'd4; h = 1'b0; end
    end else if (o) begin
      if (redirect) begin p = np; d = 1'b1; end
      if (rvalid) begin
        o = 1'b0;
        if (!d) begin h = 1'b1; r = rdata; hp = p; end
        d = 1'b0;
      end
    end else begin
      if (redirect) p = np;
      if (gnt) begin o = 1'b1; d = redirect; end
    end
    mHolding <= h; mOutstanding <= o; mDiscard <= d;
    mPc <= p; mIr <= r; mHeld <= hp;
    mStarted <= 1'b1;
  end

  // Scoreboard: every cycle compare DUT outputs to the model's predictions.
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mStarted) begin
      exp_q = '{32'(!rst && !mHolding && !mOutstanding), 32'(!rst && mHolding),
                mPc, mIr, 32'(mIr[31:26]), 32'(mIr[5:0]), mHeld};
      act_q = '{32'(imemReq), 32'(valid), imemAddr, instr, 32'(opcode), 32'(funct), pcOut};
      cmp("model_req",    act_q[0], exp_q[0]);
      cmp("model_valid",  act_q[1], exp_q[1]);
      cmp("model_addr",   act_q[2], exp_q[2]);
      cmp("model_instr",  act_q[3], exp_q[3]);
      cmp("model_opcode", act_q[4], exp_q[4]);
      cmp("model_funct",  act_q[5], exp_q[5]);
      cmp("model_pc",     act_q[6], exp_q[6]);
      if (randomPhase && valid && ready && !rst) hsCount++;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetchOne(input logic [31:0] data);
    gnt = 1'b1; step();
    gnt = 1'b0; rvalid = 1'b1; rdata = data; step();
    rvalid = 1'b0;
  endtask

  bit          memBusy;
  int          memLat;

  initial begin
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0;
    redirect = 1'b0; target = '0;
    step(); step();
    cmp("rst_valid", 32'(valid), 32'd0);
    cmp("rst_req",   32'(imemReq), 32'd0);
    cmp("rst_instr", instr, 32'd0);
    cmp("rst_pc",    pcOut, 32'd0);

    // First fetch after reset with immediate grant and response
    rst = 1'b0; gnt = 1'b1; ready = 1'b1; #1;
    cmp("first_req",  32'(imemReq), 32'd1);
    cmp("first_addr", imemAddr, 32'h3000);
    step();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h012A_4020;
    cmp("wait_noreq", 32'(imemReq), 32'd0);
    step();
    rvalid = 1'b0;
    cmp("lat_valid",  32'(valid), 32'd1);
    cmp("lat_opcode", 32'(opcode), 32'h00);
    cmp("lat_funct",  32'(funct), 32'h20);
    cmp("lat_pc",     pcOut, 32'h3000);
    step();
    cmp("next_addr", imemAddr, 32'h3004);

    // Backpressure in HOLD
    ready = 1'b0;
    fetchOne(32'hAAAA_5555);
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("bp_valid", 32'(valid), 32'd1);
      cmp("bp_instr", instr, 32'hAAAA_5555);
      cmp("bp_pc",    pcOut, 32'h3004);
      cmp("bp_req",   32'(imemReq), 32'd0);
    end
    ready = 1'b1; step();
    cmp("bp_next_addr", imemAddr, 32'h3008);

    // Redirect while waiting; late response is dropped
    gnt = 1'b1; step();
    gnt = 1'b0; redirect = 1'b1; target = 32'h4002; step();
    redirect = 1'b0;
    step(); step();
    cmp("drain_req", 32'(imemReq), 32'd0);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; step();
    rvalid = 1'b0;
    cmp("drain_valid", 32'(valid), 32'd0);
    cmp("drain_addr",  imemAddr, 32'h4000);
    cmp("drain_instr", instr, 32'hAAAA_5555);

    // Redirect together with ready in HOLD
    fetchOne(32'h1111_2222);
    redirect = 1'b1; target = 32'h5000; step();
    redirect = 1'b0;
    cmp("rdr_hold_addr", imemAddr, 32'h5000);

    // Wrap-around of PC+4
    gnt = 1'b0; redirect = 1'b1; target = 32'hFFFF_FFFF; step();
    redirect = 1'b0;
    cmp("wrap_start", imemAddr, 32'hFFFF_FFFC);
    fetchOne(32'h3333_4444);
    cmp("wrap_pc", pcOut, 32'hFFFF_FFFC);
    step();
    cmp("wrap_addr", imemAddr, 32'h0000_0000);

    // Reset while holding a valid instruction
    ready = 1'b0;
    fetchOne(32'h5555_6666);
    cmp("pre_rst_valid", 32'(valid), 32'd1);
    rst = 1'b1; step();
    cmp("hold_rst_valid", 32'(valid), 32'd0);
    cmp("hold_rst_instr", instr, 32'd0);
    rst = 1'b0; #1;
    cmp("restart_addr", imemAddr, RPC);
    cmp("restart_req",  32'(imemReq), 32'd1);

    // Randomized traffic with a responsive memory model
    randomPhase = 1'b1;
    memBusy = 1'b0; memLat = 0;
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      target   = $urandom;
      ready    = ($urandom_range(0, 2) != 0);
      rvalid   = 1'b0;
      rdata    = $urandom;
      gnt      = ($urandom_range(0, 3) != 0);
      if (rst) memBusy = 1'b0;
      else if (memBusy) begin
        if (memLat == 0) begin rvalid = 1'b1; memBusy = 1'b0; end
        else memLat--;
      end
      #1;
      if (!rst && imemReq && gnt) begin
        memBusy = 1'b1;
        memLat  = $urandom_range(0, 2);
      end
      step();
    end
    rst = 1'b0;
    cmp("random_progress", 32'(hsCount > 20), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
